mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter LOCK_MAX, default 8: the maximum number of consecutive locked grants one master may hold while the other master is requesting.
REQ-002 SHALL have the port clk, input, width 1: the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have the port rst_n, input, width 1: asynchronous, active-low reset.
REQ-004 SHALL have the port m0_req/m1_req, input, width 1: the master requests one access this cycle.
REQ-005 SHALL have the port m0_lock/m1_lock, input, width 1: the master requests to keep ownership for the following cycle.
REQ-006 SHALL have the port m0_we/m1_we, input, width 4: per-byte write enables; 4'b0000 means a read.
REQ-007 SHALL have the port m0_addr/m1_addr, input, width 18: word address.
REQ-008 SHALL have the port m0_wdata/m1_wdata, input, width 32: write data.
REQ-009 SHALL have the port m0_gnt/m1_gnt, output, width 1: the access is issued this cycle (combinational).
REQ-010 SHALL have the port m0_rvalid/m1_rvalid, output, width 1: read data valid, registered.
REQ-011 SHALL have the port m0_rdata/m1_rdata, output, width 32: read data.
REQ-012 SHALL have the port ram_addr, output, width 18: the address driven to the shared RAM port.
REQ-013 SHALL have the port ram_we, output, width 4: the byte enables driven to the shared RAM port.
REQ-014 SHALL have the port ram_wdata, output, width 32: the write data driven to the shared RAM port.
REQ-015 SHALL have the port ram_rdata, input, width 32: RAM read data, valid one cycle after the address.

Function
REQ-016 SHALL issue at most one access per cycle; m0_gnt and m1_gnt SHALL never both be 1.
REQ-017 SHALL implement the states IDLE, OWN0 and OWN1, where OWNx means master x holds a lock.
REQ-018 In IDLE, a single requester SHALL be granted in the same cycle.
REQ-019 In IDLE, when both masters request, the grant SHALL go to the master indicated by the round-robin pointer rr.
REQ-020 After every IDLE grant, rr SHALL point to the other master.
REQ-021 An IDLE grant to master x with mx_lock=1 SHALL move the state to OWNx and load lock_cnt=1.
REQ-022 In OWNx with mx_req=1, master x SHALL be granted.
REQ-023 A grant in OWNx SHALL make lock_cnt increment, saturating at LOCK_MAX, while the other master requests; otherwise lock_cnt SHALL hold.
REQ-024 OWNx SHALL return to IDLE when master x drops its lock.
REQ-025 OWNx SHALL also return to IDLE when lock_cnt==LOCK_MAX and the other master is requesting; rr SHALL then point to the other master.
REQ-026 In OWNx with mx_req=0, the other master MAY be granted that cycle, without changing the state.
REQ-027 ram_addr, ram_we and ram_wdata SHALL be a mux of the granted master's inputs.
REQ-028 With no grant, ram_we SHALL be 4'b0000 and ram_addr/ram_wdata SHALL hold their last driven value.
REQ-029 A granted read (we==0) SHALL produce rvalid=1 to that same master exactly one cycle later, with rdata=ram_rdata.
REQ-030 rvalid routing SHALL use a registered owner tag, so it is unaffected by the grant in the response cycle.
REQ-031 A granted write SHALL produce no rvalid.
REQ-032 Back-to-back reads from alternating masters SHALL each return in order, 1-cycle latency, and sustain full throughput.
REQ-033 mx_rdata of the master not receiving data SHALL hold its previous value.
REQ-034 A request without a grant SHALL NOT be queued; the master holds mx_req and the payload until it sees gnt.
REQ-035 A lock asserted with req=0 in IDLE SHALL be ignored.

Reset
REQ-036 While rst_n=0, the block SHALL be asynchronously forced to state=IDLE, rr=0 (m0 first), lock_cnt=0, rvalid outputs 0, rdata outputs 0, owner tag cleared, ram_addr=0, ram_wdata=0 and ram_we=0.
REQ-037 A reset asserted mid-lock or with a read response pending SHALL discard that response; no rvalid SHALL be produced after deassertion for pre-reset accesses.
REQ-038 The first edge after rst_n rises SHALL arbitrate normally.

Verification
REQ-039 Bench SHALL cover the post-reset contest: both request reads in cycle 0 -> m0_gnt=1; cycle 1: m1_gnt=1 and m0_rvalid=1 with m0_rdata=ram_rdata; cycle 2: m1_rvalid=1.
REQ-040 Bench SHALL cover a lock limit: with LOCK_MAX=8, m0 req+lock continuous and m1 req from cycle 0 -> m0 granted 8 consecutive cycles, m1 granted cycle 8, state IDLE.
REQ-041 Bench SHALL cover a write: m1 we=4'b0011, addr=18'h3FFFF, wdata=32'hDEADBEEF -> same-cycle ram_we=4'b0011, ram_addr=18'h3FFFF, ram_wdata=32'hDEADBEEF, with no rvalid next cycle.
REQ-042 Bench SHALL cover a lock drop: m0 lock for 3 cycles then lock=0 -> IDLE next cycle, m1 granted if requesting.
REQ-043 Bench SHALL cover reset during a pending read: m0 read granted, rst_n low before the next edge -> m0_rvalid stays 0, state IDLE, rr=0.
REQ-044 Bench SHALL cover an idle owner: in OWN0 with m0_req=0, m1_req=1 -> m1_gnt=1, state remains OWN0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a single shared synchronous RAM port.
// Round-robin contest in IDLE, bounded lock ownership, one-cycle read return.
module mem_port_arbiter #(
  parameter int LOCK_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic [3:0]  m0_we,
  input  logic [17:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic [3:0]  m1_we,
  input  logic [17:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [17:0] ram_addr,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state;
  state_t        nxt_state;
  logic          rr;
  logic          nxt_rr;
  logic [CW-1:0] lock_cnt;
  logic [CW-1:0] nxt_cnt;
  logic          g0;
  logic          g1;
  logic          ptr;
  logic          other_req;
  logic          limit_hit;
  logic          rsp_pend;
  logic          rsp_owner;
  logic [17:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata0_q;
  logic [31:0]   rdata1_q;

  assign other_req = (state == OWN0) ? m1_req : m0_req;

  // An owner that has used up its lock budget while the other master waits
  // loses the cycle: it is arbitrated as IDLE with the pointer on the waiter.
  assign limit_hit = ((state == OWN0) || (state == OWN1)) && other_req &&
                     (lock_cnt == CW'(LOCK_MAX));

  always_comb begin
    g0        = 1'b0;
    g1        = 1'b0;
    ptr       = rr;
    nxt_state = state;
    nxt_rr    = rr;
    nxt_cnt   = lock_cnt;
    if ((state == IDLE) || limit_hit) begin
      if (limit_hit) ptr = (state == OWN0);
      if (m0_req && (!m1_req || !ptr)) g0 = 1'b1;
      else if (m1_req)                 g1 = 1'b1;
      nxt_state = IDLE;
      nxt_cnt   = '0;
      if (g0) begin
        nxt_rr = 1'b1;
        if (m0_lock) begin
          nxt_state = OWN0;
          nxt_cnt   = CW'(1);
        end
      end
      if (g1) begin
        nxt_rr = 1'b0;
        if (m1_lock) begin
          nxt_state = OWN1;
          nxt_cnt   = CW'(1);
        end
      end
    end else if (state == OWN0) begin
      if (m0_req)      g0 = 1'b1;
      else if (m1_req) g1 = 1'b1;
      if (g0 && m1_req && (lock_cnt != CW'(LOCK_MAX))) nxt_cnt = lock_cnt + CW'(1);
      if (!m0_lock) begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
      end
    end else if (state == OWN1) begin
      if (m1_req)      g1 = 1'b1;
      else if (m0_req) g0 = 1'b1;
      if (g1 && m0_req && (lock_cnt != CW'(LOCK_MAX))) nxt_cnt = lock_cnt + CW'(1);
      if (!m1_lock) begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
      end
    end else begin
      nxt_state = IDLE;
      nxt_cnt   = '0;
    end
  end

  // Grants are suppressed while reset is held so the RAM port stays quiet.
  assign m0_gnt = g0 & rst_n;
  assign m1_gnt = g1 & rst_n;

  assign ram_we    = m0_gnt ? m0_we    : (m1_gnt ? m1_we    : 4'b0000);
  assign ram_addr  = m0_gnt ? m0_addr  : (m1_gnt ? m1_addr  : addr_q);
  assign ram_wdata = m0_gnt ? m0_wdata : (m1_gnt ? m1_wdata : wdata_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr       <= 1'b0;
      lock_cnt <= '0;
    end else begin
      state    <= nxt_state;
      rr       <= nxt_rr;
      lock_cnt <= nxt_cnt;
    end
  end

  // The owner tag remembers who issued the read so the response is routed
  // correctly no matter what is granted during the response cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_pend  <= 1'b0;
      rsp_owner <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rsp_pend <= (m0_gnt && (m0_we == 4'b0000)) || (m1_gnt && (m1_we == 4'b0000));
      if (m0_gnt || m1_gnt) begin
        rsp_owner <= m1_gnt;
        addr_q    <= ram_addr;
        wdata_q   <= ram_wdata;
      end
      if (m0_rvalid) rdata0_q <= ram_rdata;
      if (m1_rvalid) rdata1_q <= ram_rdata;
    end
  end

  assign m0_rvalid = rsp_pend & ~rsp_owner;
  assign m1_rvalid = rsp_pend &  rsp_owner;
  assign m0_rdata  = m0_rvalid ? ram_rdata : rdata0_q;
  assign m1_rdata  = m1_rvalid ? ram_rdata : rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: contest, streaming, writes, lock
// limit, lock drop, idle owner and reset with a read in flight.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_lock, m1_req, m1_lock;
  logic [3:0]  m0_we, m1_we;
  logic [17:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [17:0] ram_addr;
  logic [3:0]  ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int pass_cnt = 0;
  int total_cnt = 0;

  mem_port_arbiter #(.LOCK_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_req = 0; m0_lock = 0; m0_we = 4'h0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_lock = 0; m1_we = 4'h0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    m0_req = 1; m0_we = 4'hF; m0_addr = 18'h155; m0_wdata = 32'h1234;
    m1_req = 1;
    #1;
    total_cnt++; if ({m1_gnt, m0_gnt} !== 2'b00) $display("FAIL reset_gnt: got %b expected 00", {m1_gnt, m0_gnt}); else pass_cnt++;
    total_cnt++; if (ram_we !== 4'h0) $display("FAIL reset_ram_we: got %h expected 0", ram_we); else pass_cnt++;
    total_cnt++; if (ram_addr !== 18'h0) $display("FAIL reset_ram_addr: got %h expected 0", ram_addr); else pass_cnt++;
    total_cnt++; if (ram_wdata !== 32'h0) $display("FAIL reset_ram_wdata: got %h expected 0", ram_wdata); else pass_cnt++;
    total_cnt++; if ({m1_rvalid, m0_rvalid} !== 2'b00) $display("FAIL reset_rvalid: got %b expected 00", {m1_rvalid, m0_rvalid}); else pass_cnt++;
    total_cnt++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) $display("FAIL reset_rdata: got %h/%h expected 0/0", m0_rdata, m1_rdata); else pass_cnt++;
    step();
    step();
    clear_inputs();
    rst_n = 1;
  endtask

  task automatic test_contest();
    m0_req = 1; m0_addr = 18'h1;
    m1_req = 1; m1_addr = 18'h2;
    #1;
    total_cnt++; if ({m1_gnt, m0_gnt} !== 2'b01) $display("FAIL contest_c0_gnt: got %b expected 01", {m1_gnt, m0_gnt}); else pass_cnt++;
    total_cnt++; if (ram_addr !== 18'h1) $display("FAIL contest_c0_addr: got %h expected 1", ram_addr); else pass_cnt++;
    step();
    m0_req = 0; ram_rdata = 32'h1111_0000;
    #1;
    total_cnt++; if ({m1_gnt, m0_gnt} !== 2'b10) $display("FAIL contest_c1_gnt: got %b expected 10", {m1_gnt, m0_gnt}); else pass_cnt++;
    total_cnt++; if (m0_rvalid !== 1'b1) $display("FAIL contest_c1_m0_rvalid: got %b expected 1", m0_rvalid); else pass_cnt++;
    total_cnt++; if (m0_rdata !== 32'h1111_0000) $display("FAIL contest_c1_m0_rdata: got %h expected 11110000", m0_rdata); else pass_cnt++;
    step();
    m1_req = 0; ram_rdata = 32'h2222_0000;
    #1;
    total_cnt++; if ({m1_rvalid, m0_rvalid} !== 2'b10) $display("FAIL contest_c2_rvalid: got %b expected 10", {m1_rvalid, m0_rvalid}); else pass_cnt++;
    total_cnt++; if (m1_rdata !== 32'h2222_0000) $display("FAIL contest_c2_m1_rdata: got %h expected 22220000", m1_rdata); else pass_cnt++;
    total_cnt++; if (m0_rdata !== 32'h1111_0000) $display("FAIL contest_c2_m0_hold: got %h expected 11110000", m0_rdata); else pass_cnt++;
    total_cnt++; if (ram_we !== 4'h0 || ram_addr !== 18'h2) $display("FAIL contest_c2_idle_port: got we=%h addr=%h expected we=0 addr=2", ram_we, ram_addr); else pass_cnt++;
    step();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_gnt;
    logic [1:0]  exp_rv;
    for (int k = 0; k <= 4; k++) begin
      m0_req = (k < 4); m0_addr = 18'(10 + k);
      m1_req = (k < 4); m1_addr = 18'(20 + k);
      ram_rdata = 32'hB000_0000 | 32'(k);
      #1;
      exp_gnt = (k == 4) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
      exp_rv  = (k == 0) ? 2'b00 : (((k - 1) % 2 == 0) ? 2'b01 : 2'b10);
      total_cnt++; if ({m1_gnt, m0_gnt} !== exp_gnt) $display("FAIL b2b_gnt[%0d]: got %b expected %b", k, {m1_gnt, m0_gnt}, exp_gnt); else pass_cnt++;
      total_cnt++; if ({m1_rvalid, m0_rvalid} !== exp_rv) $display("FAIL b2b_rvalid[%0d]: got %b expected %b", k, {m1_rvalid, m0_rvalid}, exp_rv); else pass_cnt++;
      if (k > 0) begin
        total_cnt++;
        if ((exp_rv[0] ? m0_rdata : m1_rdata) !== (32'hB000_0000 | 32'(k)))
          $display("FAIL b2b_rdata[%0d]: got %h expected %h", k, exp_rv[0] ? m0_rdata : m1_rdata, 32'hB000_0000 | 32'(k));
        else pass_cnt++;
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_write();
    m1_req = 1; m1_we = 4'b0011; m1_addr = 18'h3FFFF; m1_wdata = 32'hDEADBEEF;
    #1;
    total_cnt++; if (m1_gnt !== 1'b1) $display("FAIL write_gnt: got %b expected 1", m1_gnt); else pass_cnt++;
    total_cnt++; if (ram_we !== 4'b0011) $display("FAIL write_ram_we: got %b expected 0011", ram_we); else pass_cnt++;
    total_cnt++; if (ram_addr !== 18'h3FFFF) $display("FAIL write_ram_addr: got %h expected 3ffff", ram_addr); else pass_cnt++;
    total_cnt++; if (ram_wdata !== 32'hDEADBEEF) $display("FAIL write_ram_wdata: got %h expected deadbeef", ram_wdata); else pass_cnt++;
    step();
    clear_inputs();
    #1;
    total_cnt++; if ({m1_rvalid, m0_rvalid} !== 2'b00) $display("FAIL write_no_rvalid: got %b expected 00", {m1_rvalid, m0_rvalid}); else pass_cnt++;
    total_cnt++; if (ram_we !== 4'h0 || ram_addr !== 18'h3FFFF || ram_wdata !== 32'hDEADBEEF)
      $display("FAIL write_hold: got we=%h addr=%h wdata=%h expected 0/3ffff/deadbeef", ram_we, ram_addr, ram_wdata); else pass_cnt++;
    step();
  endtask

  task automatic test_lock_limit();
    logic [1:0] exp_gnt;
    for (int k = 0; k <= 8; k++) begin
      m0_req = 1; m0_lock = 1; m1_req = 1;
      #1;
      exp_gnt = (k < 8) ? 2'b01 : 2'b10;
      total_cnt++; if ({m1_gnt, m0_gnt} !== exp_gnt) $display("FAIL limit_gnt[%0d]: got %b expected %b", k, {m1_gnt, m0_gnt}, exp_gnt); else pass_cnt++;
      step();
    end
    total_cnt++; if (dut.state !== 2'd0) $display("FAIL limit_state: got %0d expected 0", dut.state); else pass_cnt++;
    #1;
    total_cnt++; if ({m1_gnt, m0_gnt} !== 2'b01) $display("FAIL limit_after_gnt: got %b expected 01", {m1_gnt, m0_gnt}); else pass_cnt++;
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_lock_drop();
    m0_req = 1; m0_lock = 1;
    #1;
    total_cnt++; if ({m1_gnt, m0_gnt} !== 2'b01) $display("FAIL drop_c0_gnt: got %b expected 01", {m1_gnt, m0_gnt}); else pass_cnt++;
    step();
    for (int k = 1; k <= 3; k++) begin
      m0_req = 1; m0_lock = (k < 3); m1_req = 1;
      #1;
      total_cnt++; if ({m1_gnt, m0_gnt} !== 2'b01) $display("FAIL drop_c%0d_gnt: got %b expected 01", k, {m1_gnt, m0_gnt}); else pass_cnt++;
      step();
    end
    total_cnt++; if (dut.state !== 2'd0) $display("FAIL drop_state: got %0d expected 0", dut.state); else pass_cnt++;
    #1;
    total_cnt++; if ({m1_gnt, m0_gnt} !== 2'b10) $display("FAIL drop_c4_gnt: got %b expected 10", {m1_gnt, m0_gnt}); else pass_cnt++;
    step();
    clear_inputs();
  endtask

  task automatic test_idle_owner();
    m0_req = 1; m0_lock = 1;
    #1;
    total_cnt++; if ({m1_gnt, m0_gnt} !== 2'b01) $display("FAIL owner_c0_gnt: got %b expected 01", {m1_gnt, m0_gnt}); else pass_cnt++;
    step();
    m0_req = 0; m0_lock = 1; m1_req = 1;
    #1;
    total_cnt++; if ({m1_gnt, m0_gnt} !== 2'b10) $display("FAIL owner_c1_gnt: got %b expected 10", {m1_gnt, m0_gnt}); else pass_cnt++;
    step();
    total_cnt++; if (dut.state !== 2'd1) $display("FAIL owner_state: got %0d expected 1", dut.state); else pass_cnt++;
    m0_req = 1; m0_lock = 0; m1_req = 1;
    #1;
    total_cnt++; if ({m1_gnt, m0_gnt} !== 2'b01) $display("FAIL owner_c2_gnt: got %b expected 01", {m1_gnt, m0_gnt}); else pass_cnt++;
    step();
    clear_inputs();
    total_cnt++; if (dut.state !== 2'd0) $display("FAIL owner_exit_state: got %0d expected 0", dut.state); else pass_cnt++;
  endtask

  task automatic test_lock_ignored();
    m0_lock = 1;
    #1;
    total_cnt++; if ({m1_gnt, m0_gnt} !== 2'b00) $display("FAIL nolock_gnt: got %b expected 00", {m1_gnt, m0_gnt}); else pass_cnt++;
    step();
    total_cnt++; if (dut.state !== 2'd0) $display("FAIL nolock_state: got %0d expected 0", dut.state); else pass_cnt++;
    clear_inputs();
    step();
  endtask

  task automatic test_reset_pending();
    m0_req = 1; m0_lock = 1; m0_addr = 18'h77;
    #1;
    total_cnt++; if (m0_gnt !== 1'b1) $display("FAIL rstpend_gnt: got %b expected 1", m0_gnt); else pass_cnt++;
    #2;
    rst_n = 0;
    clear_inputs();
    step();
    total_cnt++; if (m0_rvalid !== 1'b0) $display("FAIL rstpend_rvalid: got %b expected 0", m0_rvalid); else pass_cnt++;
    total_cnt++; if (dut.state !== 2'd0) $display("FAIL rstpend_state: got %0d expected 0", dut.state); else pass_cnt++;
    total_cnt++; if (dut.rr !== 1'b0) $display("FAIL rstpend_rr: got %b expected 0", dut.rr); else pass_cnt++;
    rst_n = 1;
    m0_req = 1; m1_req = 1; ram_rdata = 32'hCAFE_0001;
    #1;
    total_cnt++; if ({m1_gnt, m0_gnt} !== 2'b01) $display("FAIL rstpend_first_gnt: got %b expected 01", {m1_gnt, m0_gnt}); else pass_cnt++;
    total_cnt++; if (m0_rvalid !== 1'b0) $display("FAIL rstpend_no_stale: got %b expected 0", m0_rvalid); else pass_cnt++;
    step();
    clear_inputs();
    #1;
    total_cnt++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hCAFE_0001) $display("FAIL rstpend_resume: got %b/%h expected 1/cafe0001", m0_rvalid, m0_rdata); else pass_cnt++;
    step();
  endtask

  initial begin
    rst_n = 0;
    ram_rdata = '0;
    clear_inputs();
    test_reset();
    test_contest();
    test_back_to_back();
    test_write();
    test_lock_limit();
    test_lock_drop();
    test_idle_owner();
    test_lock_ignored();
    test_reset_pending();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
